// File: rtl/psys_route_pkg.sv
// psys_route_pkg: definitions shared by the poly_systolic data-route blocks.
//   idw_of()     - width of a source index for a given source count
//   arb_state_t  - packet arbiter FSM states
package psys_route_pkg;

   // Width of an index that can name n sources (never below 1 bit).
   function automatic int idw_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: two-entry registered stream buffer.
//   clk, rst_n           clock, synchronous active-low reset
//   s_valid/s_ready      upstream handshake; s_ready is a flop ("skid entry empty")
//   s_payload            upstream payload
//   m_valid/m_ready      downstream handshake; m_valid is a flop
//   m_payload            downstream payload, held stable while m_valid && !m_ready
module axis_skid_buffer #(
   parameter int PAYLOAD_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [PAYLOAD_W-1:0] s_payload,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [PAYLOAD_W-1:0] m_payload
);

   logic                 out_valid_q, out_valid_d;
   logic [PAYLOAD_W-1:0] out_data_q, out_data_d;
   logic                 skid_valid_q, skid_valid_d;
   logic [PAYLOAD_W-1:0] skid_data_q, skid_data_d;
   logic                 in_ready_q, in_ready_d;
   logic                 push, pop;

   always_comb begin
      push         = s_valid && in_ready_q;
      pop          = out_valid_q && m_ready;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (!out_valid_q || pop) begin
         // Output slot frees up: the older skid entry goes first. While the
         // skid entry is full in_ready_q is low, so no push can collide here.
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
         end else begin
            out_valid_d = push;
            if (push) begin
               out_data_d = s_payload;
            end
         end
      end else if (push) begin
         // Output stalled: the beat accepted on the registered ready lands here.
         skid_valid_d = 1'b1;
         skid_data_d  = s_payload;
      end
      in_ready_d = !skid_valid_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
      end
   end

   // Skid payload is only read when skid_valid_q is set, so it needs no reset.
   always_ff @(posedge clk) begin
      skid_data_q <= skid_data_d;
   end

   assign s_ready   = in_ready_q;
   assign m_valid   = out_valid_q;
   assign m_payload = out_data_q;

endmodule

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: packet-level round-robin merge of N_SRC AXI-Stream sources.
//   clk, rst_n                     clock, synchronous active-low reset
//   s_tdata/s_tvalid/s_tlast       packed per-source streams (source i at [i*WIDTH +: WIDTH])
//   s_tready                       per-source ready, at most one bit high
//   m_tdata/m_tid/m_tvalid/m_tlast merged stream; m_tid is the source index
//   m_tready                       sink ready
//   busy                           a grant is held
//   pkt_cnt                        packets accepted on the input side, wraps
// A grant is held from the first beat until the granted source's tlast beat is
// accepted, so packets never interleave. Output goes through a 2-entry skid buffer.
module stream_rr_arbiter
   import psys_route_pkg::*;
#(
   parameter  int WIDTH = 64,
   parameter  int N_SRC = 4,
   localparam int IDW   = idw_of(N_SRC)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_SRC*WIDTH-1:0] s_tdata,
   input  logic [N_SRC-1:0]       s_tvalid,
   input  logic [N_SRC-1:0]       s_tlast,
   output logic [N_SRC-1:0]       s_tready,
   output logic [WIDTH-1:0]       m_tdata,
   output logic [IDW-1:0]         m_tid,
   output logic                   m_tvalid,
   output logic                   m_tlast,
   input  logic                   m_tready,
   output logic                   busy,
   output logic [31:0]            pkt_cnt
);

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             last;
      logic [IDW-1:0]   id;
   } axis_beat_t;

   localparam int BEAT_W = $bits(axis_beat_t);

   arb_state_t     state_q, state_d;
   logic [IDW-1:0] gnt_q, gnt_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [31:0]    pkt_cnt_q, pkt_cnt_d;
   logic           skid_in_ready;
   logic           push_valid;
   axis_beat_t     push_beat;
   axis_beat_t     out_beat;

   // First requester at or after base, searching upward and wrapping: a
   // priority encoder over req rotated so that base sits at position 0.
   function automatic logic [IDW-1:0] rr_pick(input logic [N_SRC-1:0] req,
                                              input logic [IDW-1:0]   base);
      logic [IDW-1:0] pick;
      logic           found;
      int             idx;
      pick  = base;
      found = 1'b0;
      for (int k = 0; k < N_SRC; k++) begin
         idx = (int'(base) + k) % N_SRC;
         if (!found && req[idx]) begin
            pick  = IDW'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   always_comb begin
      state_d        = state_q;
      gnt_d          = gnt_q;
      ptr_d          = ptr_q;
      pkt_cnt_d      = pkt_cnt_q;
      s_tready       = '0;
      push_valid     = 1'b0;
      push_beat.data = s_tdata[int'(gnt_q)*WIDTH +: WIDTH];
      push_beat.last = s_tlast[gnt_q];
      push_beat.id   = gnt_q;
      case (state_q)
         IDLE: begin
            if (|s_tvalid) begin
               gnt_d   = rr_pick(s_tvalid, ptr_q);
               state_d = LOCK;
            end
         end
         LOCK: begin
            // The grant is held through tvalid gaps; only tlast releases it.
            s_tready[gnt_q] = skid_in_ready;
            push_valid      = s_tvalid[gnt_q] && skid_in_ready;
            if (push_valid && s_tlast[gnt_q]) begin
               state_d   = IDLE;
               ptr_d     = (gnt_q == IDW'(N_SRC - 1)) ? '0 : gnt_q + IDW'(1);
               pkt_cnt_d = pkt_cnt_q + 32'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         ptr_q     <= '0;
         pkt_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         ptr_q     <= ptr_d;
         pkt_cnt_q <= pkt_cnt_d;
      end
   end

   axis_skid_buffer #(
      .PAYLOAD_W (BEAT_W)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_valid   (push_valid),
      .s_ready   (skid_in_ready),
      .s_payload (push_beat),
      .m_valid   (m_tvalid),
      .m_ready   (m_tready),
      .m_payload (out_beat)
   );

   assign m_tdata = out_beat.data;
   assign m_tlast = out_beat.last;
   assign m_tid   = out_beat.id;
   assign busy    = (state_q == LOCK);
   assign pkt_cnt = pkt_cnt_q;

endmodule

// File: doc/stream_rr_arbiter.md
# stream_rr_arbiter

Packet-level round-robin arbiter that merges `N_SRC` AXI-Stream sources into one AXI-Stream sink for the poly_systolic data route. Typical sources are stimulus generators or upstream route stages. Once a source is granted, the grant holds until that source's `tlast` beat is accepted, so packets are never interleaved. The output is registered through a skid buffer, and `m_tid` tags every beat with its source index so the systolic array feeder can demultiplex downstream.

## Interface
- `WIDTH`, 64: data width of each stream, in bits.
- `N_SRC`, 4: number of source ports; legal range 2..16.
- `IDW`, `$clog2(N_SRC)`: width of `m_tid` and of the grant index. This is a derived value and must not be overridden.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `s_tdata`  in  `N_SRC*WIDTH`  packed source data; source i occupies bits `[i*WIDTH +: WIDTH]`.
- `s_tvalid`  in  `N_SRC`  per-source valid.
- `s_tlast`  in  `N_SRC`  per-source last-beat-of-packet flag.
- `s_tready`  out  `N_SRC`  per-source ready; at most one bit is high in any cycle.
- `m_tdata`  out  `WIDTH`  merged data.
- `m_tid`  out  `IDW`  source index of the current output beat.
- `m_tvalid`  out  1  output valid.
- `m_tlast`  out  1  output last-beat-of-packet flag.
- `m_tready`  in  1  sink ready.
- `busy`  out  1  high while a grant is held (state LOCK).
- `pkt_cnt`  out  32  number of packets accepted from all sources; wraps modulo 2^32.

## Operation
- The FSM has two states, IDLE and LOCK.
- IDLE:
  - All `s_tready` bits are 0.
  - If any `s_tvalid` is high, select the first requester at or after `ptr`, searching circularly upward (`ptr`, `ptr+1`, … wrapping to 0).
  - Register that index as `gnt` and move to LOCK.
  - If no `s_tvalid` is high, stay in IDLE.
- LOCK:
  - `s_tready[gnt] = skid_in_ready`; every other `s_tready` bit is 0.
  - A beat is accepted when `s_tvalid[gnt] && s_tready[gnt]`. The accepted beat `{s_tdata[gnt], s_tlast[gnt], gnt}` is pushed into the skid buffer.
  - If the granted source drops `tvalid` mid-packet, the grant is held regardless of requests from other sources. There is no timeout.
  - When the accepted beat has `tlast`:
    - Return to IDLE.
    - `ptr <= (gnt == N_SRC-1) ? 0 : gnt+1`.
    - `pkt_cnt <= pkt_cnt + 1`.
- Fairness: with all sources continuously requesting, grants rotate 0,1,…,N_SRC-1,0,…. No source waits more than `N_SRC-1` packets.
- A source that raises `tvalid` in the same cycle the FSM is in IDLE takes part in that cycle's arbitration.
- Data integrity: no beat is dropped, duplicated or reordered, whatever the `m_tready` pattern.
- Reset, including mid-packet:
  - state ← IDLE, `ptr` ← 0, `gnt` ← 0, `pkt_cnt` ← 0.
  - The skid buffer is emptied, so buffered beats are discarded.
  - The partially transferred packet is not completed. Sources are responsible for restarting it.

## Timing
- Values during and after reset: `m_tvalid` 0, `m_tlast` 0, `m_tdata` 0, `m_tid` 0, `s_tready` all 0, `busy` 0, `pkt_cnt` 0.
- Arbitration cost: the IDLE state takes exactly 1 cycle per packet, during which no `s_tready` is high. The first beat can be accepted at the earliest 1 cycle after the request is seen in IDLE.
- Latency: a beat accepted on the input in cycle t is presented on `m_*` in cycle t+1, provided the skid buffer was empty.
- Throughput: 1 beat/cycle while in LOCK with `m_tready` held high. An N-beat packet occupies N+1 cycles, including the IDLE cycle.
- `m_*` handshake:
  - Once `m_tvalid` is high, `m_tdata`, `m_tlast` and `m_tid` hold stable until `m_tready` is seen.
  - `m_tvalid` does not depend combinationally on `m_tready`.
- Skid buffer: 2 entries.
  - `skid_in_ready` is registered and equals "second entry empty".
  - With `m_tready` low, at most 2 beats are absorbed.
  - If the buffer is full and `m_tready` rises, the buffer drains in order while accepting one new beat per cycle.
- `pkt_cnt` updates in the cycle after the `tlast` input handshake. It counts input acceptance, not output acceptance.

## Structure
- Shared package `psys_route_pkg`:
  - `IDW` derivation function.
  - FSM enum typedef `arb_state_t {IDLE, LOCK}`.
  - Beat struct typedef `axis_beat_t` (data, last, id), parameterised through the module via a localparam width.
- Sub-module `axis_skid_buffer`, parameterised by payload width:
  - Carries `{tdata, tlast, tid}`.
  - Registered `s_tready` and registered `m_tvalid`.
  - Has its own synchronous active-low reset on the same `rst_n`.
- The round-robin search is a combinational function in the arbiter: a masked priority encoder over `s_tvalid` rotated by `ptr`.

## Test plan
- **Single source:** source 2 sends a 4-beat packet D0..D3 while `m_tready=1`.
  - Expected: `m_tid=2` on all 4 beats, `m_tlast` only on D3, `pkt_cnt=1`, `ptr=3`.
- **Simultaneous request:** sources 0 and 1 each present a 3-beat packet in the same cycle after reset.
  - Expected: all of source 0's beats, then all of source 1's beats, with no interleaving and a 1-cycle gap between packets.
- **Rotation:** all 4 sources request continuously with 2-beat packets for 12 packets.
  - Expected: `m_tid` packet order 0,1,2,3 repeated 3 times, `pkt_cnt=12`.
- **Random stalls:** the granted source toggles `tvalid` randomly mid-packet while source 3 also requests.
  - Expected: the grant is held until `tlast`; source 3 appears only afterwards.
- **Output backpressure:** `m_tready` is randomised at 30% high over a 64-beat packet.
  - Expected: the output sequence equals the input sequence exactly, at most 2 beats are accepted while `m_tready` stays low, and `m_*` stays stable during stalls.
- **Reset mid-packet:** assert `rst_n=0` at beat 3 of 8.
  - Expected: next cycle `m_tvalid=0`, `busy=0`, `pkt_cnt=0`, all `s_tready` 0. A new packet from source 1 after reset is then granted normally, with `ptr` at 0.
